// File: rtl/sat_fsm_pkg.sv
// Shared mode encodings, sizing constants and transition helpers for the TMR mode FSM.
package sat_fsm_pkg;

    localparam int unsigned MODE_W        = 3;
    localparam int unsigned N_REPLICA     = 3;
    localparam int unsigned SAFE_HOLD_DEF = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_SAFE     = 3'b000,
        MODE_IDLE     = 3'b001,
        MODE_DETUMBLE = 3'b010,
        MODE_NOMINAL  = 3'b011,
        MODE_COMM     = 3'b100
    } mode_e;

    // Unused codes collapse to SAFE so a corrupted vote always lands somewhere safe.
    function automatic mode_e decode_mode(input logic [MODE_W-1:0] v);
        mode_e m;
        case (v)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: m = mode_e'(v);
            default:                                m = MODE_SAFE;
        endcase
        return m;
    endfunction

    function automatic logic cmd_legal(input mode_e cur, input logic [MODE_W-1:0] req);
        logic ok;
        ok = 1'b0;
        case (cur)
            MODE_IDLE:     ok = (req == MODE_DETUMBLE) || (req == MODE_SAFE);
            MODE_DETUMBLE: ok = (req == MODE_NOMINAL) || (req == MODE_IDLE) || (req == MODE_SAFE);
            MODE_NOMINAL:  ok = (req == MODE_COMM) || (req == MODE_IDLE) || (req == MODE_SAFE);
            MODE_COMM:     ok = (req == MODE_NOMINAL) || (req == MODE_IDLE) || (req == MODE_SAFE);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tmr_voter3.sv
// Bitwise 2-of-3 majority vote with a flag for any replica disagreement.
module tmr_voter3
    import sat_fsm_pkg::*;
(
    input  logic [MODE_W-1:0] a,
    input  logic [MODE_W-1:0] b,
    input  logic [MODE_W-1:0] c,
    output logic [MODE_W-1:0] maj,
    output logic              disagree
);

    assign maj      = (a & b) | (a & c) | (b & c);
    assign disagree = (a != b) || (b != c);

endmodule

// File: rtl/sat_mode_fsm_tmr.sv
// Satellite mode FSM with triple-redundant state, per-edge scrubbing and SEU injection hook.
module sat_mode_fsm_tmr
    import sat_fsm_pkg::*;
#(
    parameter int unsigned SAFE_HOLD = SAFE_HOLD_DEF,
    parameter int unsigned ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_mode,
    input  logic              fault_flag,
    input  logic              batt_low,
    input  logic              seu_en,
    input  logic [1:0]        seu_sel,
    input  logic [2:0]        seu_mask,
    output logic [2:0]        mode,
    output logic              mismatch,
    output logic              cmd_reject,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned HOLD_W = (SAFE_HOLD > 1) ? $clog2(SAFE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SAFE_HOLD - 1);

    logic [MODE_W-1:0] rep_q [N_REPLICA];
    logic [MODE_W-1:0] rep_d [N_REPLICA];
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              reject_q, reject_d;
    logic [MODE_W-1:0] voted;
    logic [MODE_W-1:0] next_mode;
    mode_e             cur;

    tmr_voter3 u_voter (
        .a        (rep_q[0]),
        .b        (rep_q[1]),
        .c        (rep_q[2]),
        .maj      (voted),
        .disagree (mismatch)
    );

    // State register: every replica reloads each edge, which scrubs any single upset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REPLICA); i++) rep_q[i] <= MODE_SAFE;
            hold_q   <= '0;
            err_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_REPLICA); i++) rep_q[i] <= rep_d[i];
            hold_q   <= hold_d;
            err_q    <= err_d;
            reject_q <= reject_d;
        end
    end

    // Next-state from the voted mode; priority fault > battery > SAFE timeout > command.
    always_comb begin
        cur       = decode_mode(voted);
        next_mode = cur;
        hold_d    = '0;
        reject_d  = 1'b0;

        if (fault_flag) begin
            next_mode = MODE_SAFE;
            reject_d  = cmd_valid;
        end else if (batt_low && (cur == MODE_NOMINAL || cur == MODE_COMM)) begin
            next_mode = MODE_IDLE;
            reject_d  = cmd_valid;
        end else if (cur == MODE_SAFE && hold_q == HOLD_LAST) begin
            next_mode = MODE_IDLE;
            reject_d  = cmd_valid;
        end else begin
            if (cur == MODE_SAFE) hold_d = hold_q + HOLD_W'(1);
            if (cmd_valid) begin
                if (cmd_legal(cur, cmd_mode)) next_mode = cmd_mode;
                else                          reject_d  = 1'b1;
            end
        end

        for (int i = 0; i < int'(N_REPLICA); i++) begin
            rep_d[i] = next_mode;
            if (seu_en && seu_sel == 2'(i)) rep_d[i] = next_mode ^ seu_mask;
        end

        err_d = err_q;
        if (mismatch && err_q != '1) err_d = err_q + ERR_W'(1);
    end

    assign mode       = voted;
    assign cmd_reject = reject_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_sat_mode_fsm_tmr.sv
// Directed plus randomized bench for sat_mode_fsm_tmr against a behavioural mode model.
module tb_sat_mode_fsm_tmr;

    localparam int SAFE_HOLD = 16;
    localparam int ERR_W     = 8;
    localparam int ERR_MAX   = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic [2:0]       cmd_mode;
    logic             fault_flag;
    logic             batt_low;
    logic             seu_en;
    logic [1:0]       seu_sel;
    logic [2:0]       seu_mask;
    logic [2:0]       mode;
    logic             mismatch;
    logic             cmd_reject;
    logic [ERR_W-1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: three replica values, hold count, error count, reject flag.
    int m_rep [3];
    int m_hold;
    int m_err;
    int m_rej;
    bit allowed [8][8];

    sat_mode_fsm_tmr #(.SAFE_HOLD(SAFE_HOLD), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_mode   (cmd_mode),
        .fault_flag (fault_flag),
        .batt_low   (batt_low),
        .seu_en     (seu_en),
        .seu_sel    (seu_sel),
        .seu_mask   (seu_mask),
        .mode       (mode),
        .mismatch   (mismatch),
        .cmd_reject (cmd_reject),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int vote3(input int a, input int b, input int c);
        int r = 0;
        for (int k = 0; k < 3; k++)
            if (((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1) >= 2) r |= (1 << k);
        return r;
    endfunction

    function automatic int model_mismatch();
        return (m_rep[0] == m_rep[1] && m_rep[1] == m_rep[2]) ? 0 : 1;
    endfunction

    task automatic model_edge();
        int v, cur, nxt, nh, rj, mm;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_rep[i] = 0;
            m_hold = 0; m_err = 0; m_rej = 0;
            return;
        end
        v   = vote3(m_rep[0], m_rep[1], m_rep[2]);
        cur = (v > 4) ? 0 : v;
        mm  = model_mismatch();
        nxt = cur; nh = 0; rj = 0;
        if (fault_flag) begin
            nxt = 0; rj = int'(cmd_valid);
        end else if (batt_low && cur >= 3) begin
            nxt = 1; rj = int'(cmd_valid);
        end else if (cur == 0 && m_hold == SAFE_HOLD - 1) begin
            nxt = 1; rj = int'(cmd_valid);
        end else begin
            if (cur == 0) nh = m_hold + 1;
            if (cmd_valid) begin
                if (allowed[cur][int'(cmd_mode)]) nxt = int'(cmd_mode);
                else                              rj = 1;
            end
        end
        for (int i = 0; i < 3; i++)
            m_rep[i] = (seu_en && int'(seu_sel) == i) ? (nxt ^ int'(seu_mask)) : nxt;
        if (mm != 0 && m_err < ERR_MAX) m_err++;
        m_hold = nh;
        m_rej  = rj;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("model_mode",     int'(mode),       vote3(m_rep[0], m_rep[1], m_rep[2]));
        check("model_mismatch", int'(mismatch),   model_mismatch());
        check("model_reject",   int'(cmd_reject), m_rej);
        check("model_err",      int'(err_cnt),    m_err);
    endtask

    task automatic quiet();
        cmd_valid = 0; cmd_mode = 0; fault_flag = 0; batt_low = 0;
        seu_en = 0; seu_sel = 2'd3; seu_mask = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic cmd_tick(input logic [2:0] m);
        cmd_valid = 1; cmd_mode = m;
        tick();
        cmd_valid = 0;
    endtask

    initial begin
        allowed[1][2] = 1; allowed[2][3] = 1; allowed[3][4] = 1; allowed[4][3] = 1;
        for (int s = 1; s <= 4; s++) begin
            allowed[s][0] = 1;
            if (s >= 2) allowed[s][1] = 1;
        end
        for (int i = 0; i < 3; i++) m_rep[i] = 0;
        m_hold = 0; m_err = 0; m_rej = 0;
        quiet();
        rst_n = 0;

        // Reset state
        tick(); tick();
        check("rst_mode", int'(mode), 0);
        check("rst_mismatch", int'(mismatch), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_reject", int'(cmd_reject), 0);

        // SAFE auto-exit after SAFE_HOLD quiet cycles
        rst_n = 1;
        for (int i = 0; i < 15; i++) tick();
        check("hold_15_still_safe", int'(mode), 0);
        tick();
        check("hold_16_idle", int'(mode), 1);
        check("hold_err", int'(err_cnt), 0);

        // Legal command walk, then an illegal one
        cmd_tick(3'b010); check("cmd_detumble", int'(mode), 2);
        cmd_tick(3'b011); check("cmd_nominal", int'(mode), 3);
        cmd_tick(3'b100); check("cmd_comm", int'(mode), 4);
        cmd_tick(3'b010);
        check("illegal_mode", int'(mode), 4);
        check("illegal_reject", int'(cmd_reject), 1);
        tick();
        check("reject_one_cycle", int'(cmd_reject), 0);

        // Battery low overrides a concurrent command in COMM
        batt_low = 1;
        cmd_tick(3'b011);
        batt_low = 0;
        check("batt_mode", int'(mode), 1);
        check("batt_reject", int'(cmd_reject), 1);

        // Single SEU in NOMINAL is masked and scrubbed
        cmd_tick(3'b010); cmd_tick(3'b011);
        seu_en = 1; seu_sel = 2'd1; seu_mask = 3'b111;
        tick();
        quiet();
        check("seu_mode", int'(mode), 3);
        check("seu_mismatch", int'(mismatch), 1);
        tick();
        check("seu_scrubbed", int'(mismatch), 0);
        check("seu_err", int'(err_cnt), 1);

        // Persistent SEU saturates the error counter
        seu_en = 1; seu_sel = 2'd2; seu_mask = 3'b101;
        for (int i = 0; i < 300; i++) tick();
        quiet();
        check("sat_mode", int'(mode), 3);
        check("sat_err", int'(err_cnt), ERR_MAX);
        tick();
        check("sat_err_hold", int'(err_cnt), ERR_MAX);

        // Reset wins over a simultaneous fault in COMM; hold restarts from zero
        cmd_tick(3'b100);
        fault_flag = 1; rst_n = 0;
        tick();
        check("rstfault_mode", int'(mode), 0);
        check("rstfault_err", int'(err_cnt), 0);
        check("rstfault_mismatch", int'(mismatch), 0);
        fault_flag = 0; rst_n = 1;
        for (int i = 0; i < 15; i++) tick();
        check("rehold_safe", int'(mode), 0);
        tick();
        check("rehold_idle", int'(mode), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            fault_flag = ($urandom_range(0, 19) == 0);
            batt_low   = ($urandom_range(0, 7) == 0);
            cmd_valid  = ($urandom_range(0, 2) == 0);
            cmd_mode   = 3'($urandom_range(0, 7));
            seu_en     = ($urandom_range(0, 7) == 0);
            seu_sel    = 2'($urandom_range(0, 3));
            seu_mask   = 3'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
